// File: rtl/ula_main_control.sv
// Multicycle main control FSM for the RV32I core: sequences fetch/decode/execute/
// memory/writeback and drives every datapath mux, write-enable and memory strobe.
//
//   state    | meaning
//   IDLE     | post-reset, all outputs 0
//   FETCH    | read instruction at PC, PC+4 on handshake
//   DECODE   | opcode dispatch, branch/JAL target into ULAOut
//   EXEC_R   | rs1 op rs2 (funct-driven)
//   EXEC_I   | rs1 op imm (funct-driven)
//   LUI      | 0 + imm
//   AUIPC    | old_pc + imm
//   ALU_WB   | write ULAOut to rd
//   MEM_ADDR | rs1 + imm effective address
//   MEM_RD   | load access, waits on mem_ready
//   MEM_WB   | write MDR to rd
//   MEM_WR   | store access, waits on mem_ready
//   BRANCH   | compare, conditional PC load from ULAOut
//   JAL      | link, PC from ULAOut
//   JALR     | link, PC from rs1 + imm
//   TRAP     | illegal opcode
module ula_main_control #(
  parameter bit TRAP_STICKY = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic [1:0] ula_op,
  output logic [1:0] ula_src_a,
  output logic [1:0] ula_src_b,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] mem_to_reg,
  output logic       retire,
  output logic       illegal
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_EXEC_R   = 4'd3;
  localparam logic [3:0] S_EXEC_I   = 4'd4;
  localparam logic [3:0] S_LUI      = 4'd5;
  localparam logic [3:0] S_AUIPC    = 4'd6;
  localparam logic [3:0] S_ALU_WB   = 4'd7;
  localparam logic [3:0] S_MEM_ADDR = 4'd8;
  localparam logic [3:0] S_MEM_RD   = 4'd9;
  localparam logic [3:0] S_MEM_WB   = 4'd10;
  localparam logic [3:0] S_MEM_WR   = 4'd11;
  localparam logic [3:0] S_BRANCH   = 4'd12;
  localparam logic [3:0] S_JAL      = 4'd13;
  localparam logic [3:0] S_JALR     = 4'd14;
  localparam logic [3:0] S_TRAP     = 4'd15;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic [3:0] state;
  logic [3:0] next_state;
  logic       is_load;

  // The opcode is only trusted in DECODE, so the load/store choice is kept here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      is_load <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_DECODE) is_load <= (opcode == OP_LOAD);
    end
  end

  always_comb begin
    next_state = S_IDLE;
    case (state)
      S_IDLE:     next_state = S_FETCH;
      S_FETCH:    next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_R:               next_state = S_EXEC_R;
          OP_I:               next_state = S_EXEC_I;
          OP_LOAD, OP_STORE:  next_state = S_MEM_ADDR;
          OP_BRANCH:          next_state = S_BRANCH;
          OP_JAL:             next_state = S_JAL;
          OP_JALR:            next_state = S_JALR;
          OP_LUI:             next_state = S_LUI;
          OP_AUIPC:           next_state = S_AUIPC;
          default:            next_state = S_TRAP;
        endcase
      end
      S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC: next_state = S_ALU_WB;
      S_MEM_ADDR: next_state = is_load ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   next_state = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   next_state = mem_ready ? S_FETCH : S_MEM_WR;
      S_ALU_WB, S_MEM_WB, S_BRANCH, S_JAL, S_JALR: next_state = S_FETCH;
      S_TRAP:     next_state = TRAP_STICKY ? S_TRAP : S_FETCH;
      default:    next_state = S_IDLE;
    endcase
  end

  always_comb begin
    ula_op        = 2'b00;
    ula_src_a     = 2'b00;
    ula_src_b     = 2'b00;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    ir_write      = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 2'b00;
    retire        = 1'b0;
    illegal       = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        ula_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE, S_AUIPC: begin
        ula_src_a = 2'b10;
        ula_src_b = 2'b10;
      end
      S_EXEC_R: begin
        ula_src_a = 2'b01;
        ula_op    = 2'b10;
      end
      S_EXEC_I: begin
        ula_src_a = 2'b01;
        ula_src_b = 2'b10;
        ula_op    = 2'b11;
      end
      S_LUI: begin
        ula_src_a = 2'b11;
        ula_src_b = 2'b10;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_MEM_ADDR: begin
        ula_src_a = 2'b01;
        ula_src_b = 2'b10;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
        retire     = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        retire    = mem_ready;
      end
      S_BRANCH: begin
        ula_src_a     = 2'b01;
        ula_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        retire        = 1'b1;
      end
      S_JAL: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b10;
        pc_write   = 1'b1;
        pc_source  = 2'b01;
        retire     = 1'b1;
      end
      S_JALR: begin
        ula_src_a  = 2'b01;
        ula_src_b  = 2'b10;
        reg_write  = 1'b1;
        mem_to_reg = 2'b10;
        pc_write   = 1'b1;
        retire     = 1'b1;
      end
      S_TRAP:  illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ula_main_control.sv
// Bench for ula_main_control: each opcode expands into a plan of expected output
// vectors taken from the instruction's micro-step table; both TRAP_STICKY builds run side by side.
module tb_ula_main_control;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic       mem_ready;

  logic [1:0] ula_op_s, src_a_s, src_b_s, pc_source_s, mem_to_reg_s;
  logic       pc_write_s, pc_write_cond_s, ir_write_s, iord_s, mem_read_s, mem_write_s;
  logic       reg_write_s, retire_s, illegal_s;
  logic [1:0] ula_op_n, src_a_n, src_b_n, pc_source_n, mem_to_reg_n;
  logic       pc_write_n, pc_write_cond_n, ir_write_n, iord_n, mem_read_n, mem_write_n;
  logic       reg_write_n, retire_n, illegal_n;

  ula_main_control #(.TRAP_STICKY(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .ula_op(ula_op_s), .ula_src_a(src_a_s), .ula_src_b(src_b_s),
    .pc_write(pc_write_s), .pc_write_cond(pc_write_cond_s), .pc_source(pc_source_s),
    .ir_write(ir_write_s), .iord(iord_s), .mem_read(mem_read_s), .mem_write(mem_write_s),
    .reg_write(reg_write_s), .mem_to_reg(mem_to_reg_s), .retire(retire_s), .illegal(illegal_s)
  );

  ula_main_control #(.TRAP_STICKY(1'b0)) dut_ns (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .ula_op(ula_op_n), .ula_src_a(src_a_n), .ula_src_b(src_b_n),
    .pc_write(pc_write_n), .pc_write_cond(pc_write_cond_n), .pc_source(pc_source_n),
    .ir_write(ir_write_n), .iord(iord_n), .mem_read(mem_read_n), .mem_write(mem_write_n),
    .reg_write(reg_write_n), .mem_to_reg(mem_to_reg_n), .retire(retire_n), .illegal(illegal_n)
  );

  logic [18:0] obs_s, obs_n;
  assign obs_s = {ula_op_s, src_a_s, src_b_s, pc_write_s, pc_write_cond_s, pc_source_s, ir_write_s,
                  iord_s, mem_read_s, mem_write_s, reg_write_s, mem_to_reg_s, retire_s, illegal_s};
  assign obs_n = {ula_op_n, src_a_n, src_b_n, pc_write_n, pc_write_cond_n, pc_source_n, ir_write_n,
                  iord_n, mem_read_n, mem_write_n, reg_write_n, mem_to_reg_n, retire_n, illegal_n};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [18:0] base;
    logic [18:0] extra;
    bit          hs;
  } step_t;

  step_t plan[$];
  int    total = 0;
  int    bad = 0;
  int    rcount;
  logic [6:0] legal [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

  function automatic logic [18:0] ov(logic [1:0] op, logic [1:0] a, logic [1:0] b, logic pcw,
                                     logic pcwc, logic [1:0] pcs, logic irw, logic io, logic mr,
                                     logic mw, logic rw, logic [1:0] m2r, logic ret, logic ill);
    return {op, a, b, pcw, pcwc, pcs, irw, io, mr, mw, rw, m2r, ret, ill};
  endfunction

  function automatic step_t mk(logic [18:0] base, logic [18:0] extra, bit hs);
    step_t s;
    s.base = base; s.extra = extra; s.hs = hs;
    return s;
  endfunction

  task automatic build(input logic [6:0] op);
    logic [18:0] alu_wb;
    alu_wb = ov(0,0,0, 0,0,0, 0,0,0,0, 1,0, 1,0);
    plan.delete();
    plan.push_back(mk(ov(0,0,1, 0,0,0, 0,0,1,0, 0,0, 0,0), ov(0,0,0, 1,0,0, 1,0,0,0, 0,0, 0,0), 1));
    plan.push_back(mk(ov(0,2,2, 0,0,0, 0,0,0,0, 0,0, 0,0), '0, 0));
    case (op)
      7'b0110011: begin plan.push_back(mk(ov(2,1,0, 0,0,0, 0,0,0,0, 0,0, 0,0), '0, 0));
                        plan.push_back(mk(alu_wb, '0, 0)); end
      7'b0010011: begin plan.push_back(mk(ov(3,1,2, 0,0,0, 0,0,0,0, 0,0, 0,0), '0, 0));
                        plan.push_back(mk(alu_wb, '0, 0)); end
      7'b0110111: begin plan.push_back(mk(ov(0,3,2, 0,0,0, 0,0,0,0, 0,0, 0,0), '0, 0));
                        plan.push_back(mk(alu_wb, '0, 0)); end
      7'b0010111: begin plan.push_back(mk(ov(0,2,2, 0,0,0, 0,0,0,0, 0,0, 0,0), '0, 0));
                        plan.push_back(mk(alu_wb, '0, 0)); end
      7'b0000011: begin plan.push_back(mk(ov(0,1,2, 0,0,0, 0,0,0,0, 0,0, 0,0), '0, 0));
                        plan.push_back(mk(ov(0,0,0, 0,0,0, 0,1,1,0, 0,0, 0,0), '0, 1));
                        plan.push_back(mk(ov(0,0,0, 0,0,0, 0,0,0,0, 1,1, 1,0), '0, 0)); end
      7'b0100011: begin plan.push_back(mk(ov(0,1,2, 0,0,0, 0,0,0,0, 0,0, 0,0), '0, 0));
                        plan.push_back(mk(ov(0,0,0, 0,0,0, 0,1,0,1, 0,0, 0,0),
                                          ov(0,0,0, 0,0,0, 0,0,0,0, 0,0, 1,0), 1)); end
      7'b1100011: plan.push_back(mk(ov(1,1,0, 0,1,1, 0,0,0,0, 0,0, 1,0), '0, 0));
      7'b1101111: plan.push_back(mk(ov(0,0,0, 1,0,1, 0,0,0,0, 1,2, 1,0), '0, 0));
      7'b1100111: plan.push_back(mk(ov(0,1,2, 1,0,0, 0,0,0,0, 1,2, 1,0), '0, 0));
      default:    plan.push_back(mk(ov(0,0,0, 0,0,0, 0,0,0,0, 0,0, 0,1), '0, 0));
    endcase
  endtask

  task automatic chk(input string tag, input logic [18:0] exp_s, input logic [18:0] exp_n);
    total++;
    assert (obs_s === exp_s) else begin
      bad++;
      $error("FAIL %s sticky obs=%05h exp=%05h", tag, obs_s, exp_s);
    end
    total++;
    assert (obs_n === exp_n) else begin
      bad++;
      $error("FAIL %s nonsticky obs=%05h exp=%05h", tag, obs_n, exp_n);
    end
  endtask

  task automatic cycle(input string tag, input step_t st, input logic rdy);
    logic [18:0] e;
    mem_ready = rdy;
    #1;
    e = st.base | ((st.hs && rdy) ? st.extra : 19'd0);
    chk(tag, e, e);
    rcount += int'(retire_s);
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from FETCH; handshake steps see `wait` cycles of mem_ready=0.
  task automatic do_instr(input string tag, input logic [6:0] op, input int fwait, input int mwait);
    int w, n;
    opcode = op;
    build(op);
    rcount = 0;
    for (int k = 0; k < plan.size(); k++) begin
      w = (k == 0) ? fwait : mwait;
      n = plan[k].hs ? w + 1 : 1;
      for (int i = 0; i < n; i++)
        cycle(tag, plan[k], plan[k].hs ? logic'(i == n - 1) : logic'($urandom_range(0, 1)));
    end
    total++;
    assert (rcount === (plan[plan.size()-1].base[0] ? 0 : 1)) else begin
      bad++;
      $error("FAIL %s retire_count obs=%0d exp=%0d", tag, rcount,
             plan[plan.size()-1].base[0] ? 0 : 1);
    end
  endtask

  initial begin
    logic [18:0] fetch0, trapv;
    fetch0 = ov(0,0,1, 0,0,0, 0,0,1,0, 0,0, 0,0);
    trapv  = ov(0,0,0, 0,0,0, 0,0,0,0, 0,0, 0,1);
    rst_n = 1'b0; mem_ready = 1'b0; opcode = 7'd0;
    #1;
    chk("reset", 19'd0, 19'd0);
    mem_ready = 1'b1;
    #11 rst_n = 1'b1;
    #1;
    chk("idle", 19'd0, 19'd0);
    @(posedge clk); #1;

    do_instr("rtype",  7'b0110011, 0, 0);
    do_instr("load_wait", 7'b0000011, 0, 3);
    do_instr("store_fstall", 7'b0100011, 2, 0);
    do_instr("store_wait", 7'b0100011, 0, 2);
    do_instr("branch", 7'b1100011, 0, 0);
    do_instr("jal",    7'b1101111, 1, 0);
    do_instr("jalr",   7'b1100111, 0, 0);
    do_instr("itype",  7'b0010011, 0, 0);
    do_instr("lui",    7'b0110111, 0, 0);
    do_instr("auipc",  7'b0010111, 0, 0);

    // Asynchronous reset while a load is stalled in MEM_RD.
    opcode = 7'b0000011;
    build(7'b0000011);
    cycle("ar_fetch", plan[0], 1'b1);
    cycle("ar_decode", plan[1], 1'b0);
    cycle("ar_addr", plan[2], 1'b1);
    mem_ready = 1'b0;
    #1;
    chk("ar_memrd", plan[3].base, plan[3].base);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_async", 19'd0, 19'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int r = 0; r < 40; r++)
      do_instr("random", legal[$urandom_range(0, 8)], $urandom_range(0, 2), $urandom_range(0, 3));

    do_instr("trap", 7'b1111111, 0, 0);
    for (int i = 0; i < 12; i++) begin
      mem_ready = 1'b0;
      #1;
      chk("trap_hold", trapv, fetch0);
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
